// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared ALU opcode encodings, illegal-opcode bound and slot state type
package alu_arbiter_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLL  = 4'd2,
        OP_SLT  = 4'd3,
        OP_SLTU = 4'd4,
        OP_XOR  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_OR   = 4'd8,
        OP_AND  = 4'd9
    } op_t;

    localparam logic [3:0] OP_MAX = 4'd9;

    typedef enum logic {EMPTY, FULL} slot_t;

    function automatic logic op_illegal(input logic [3:0] op);
        return op > OP_MAX;
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu: combinational ALU with zero and illegal-opcode flags
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [3:0]        op,
    input  logic [DWIDTH-1:0] a,
    input  logic [DWIDTH-1:0] b,
    output logic [DWIDTH-1:0] result,
    output logic              zero,
    output logic              illegal
);

    // Opcode decode; illegal opcodes fall to the default and yield zero data
    always_comb begin
        result  = '0;
        illegal = op_illegal(op);
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_SLL:  result = a << b;
            OP_SLT:  result = {{(DWIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: result = {{(DWIDTH-1){1'b0}}, a < b};
            OP_XOR:  result = a ^ b;
            OP_SRL:  result = a >> b;
            OP_SRA:  result = $unsigned($signed(a) >>> b);
            OP_OR:   result = a | b;
            OP_AND:  result = a & b;
            default: result = '0;
        endcase
        zero = result == '0;
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between two requesters with registered response slots
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DWIDTH-1:0] req0_a,
    input  logic [DWIDTH-1:0] req0_b,
    input  logic [3:0]        req0_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DWIDTH-1:0] rsp0_data,
    output logic              rsp0_zero,
    output logic              rsp0_illegal,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DWIDTH-1:0] req1_a,
    input  logic [DWIDTH-1:0] req1_b,
    input  logic [3:0]        req1_op,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DWIDTH-1:0] rsp1_data,
    output logic              rsp1_zero,
    output logic              rsp1_illegal
);

    slot_t [1:0]       state;
    slot_t [1:0]       state_next;
    logic  [1:0]       full;
    logic  [1:0]       elig;
    logic  [1:0]       gnt;
    logic              prio;
    logic [DWIDTH-1:0] alu_a;
    logic [DWIDTH-1:0] alu_b;
    logic [3:0]        alu_op;
    logic [DWIDTH-1:0] alu_result;
    logic              alu_zero;
    logic              alu_illegal;

    // Eligibility needs a free slot; prio breaks ties, reset forces no grant
    always_comb begin
        elig[0] = rst_n & req0_valid & (~full[0] | rsp0_ready);
        elig[1] = rst_n & req1_valid & (~full[1] | rsp1_ready);
        gnt[0]  = elig[0] & (~elig[1] | ~prio);
        gnt[1]  = elig[1] & (~elig[0] | prio);
        alu_a   = gnt[1] ? req1_a  : gnt[0] ? req0_a  : '0;
        alu_b   = gnt[1] ? req1_b  : gnt[0] ? req0_b  : '0;
        alu_op  = gnt[1] ? req1_op : gnt[0] ? req0_op : 4'(OP_ADD);
    end

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign rsp0_valid = full[0];
    assign rsp1_valid = full[1];

    alu_arbiter_alu #(.DWIDTH(DWIDTH)) u_alu (
        .op      (alu_op),
        .a       (alu_a),
        .b       (alu_b),
        .result  (alu_result),
        .zero    (alu_zero),
        .illegal (alu_illegal)
    );

    // Slot FSMs: a handshake (re)loads the slot, a consume without reload empties it
    always_comb begin
        state_next = state;
        full       = '0;
        for (int i = 0; i < 2; i++) begin
            full[i]       = state[i] == FULL;
            state_next[i] = gnt[i] ? FULL :
                            (state[i] == FULL && (i == 0 ? rsp0_ready : rsp1_ready)) ? EMPTY : state[i];
        end
    end

    // Slot state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= {EMPTY, EMPTY};
        else        state <= state_next;
    end

    // Round-robin pointer moves to the requester that lost this grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    prio <= 1'b0;
        else if (|gnt) prio <= gnt[0];
    end

    // Response payload registers capture the ALU on their requester's handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {rsp0_data, rsp0_zero, rsp0_illegal} <= '0;
            {rsp1_data, rsp1_zero, rsp1_illegal} <= '0;
        end else begin
            if (gnt[0]) {rsp0_data, rsp0_zero, rsp0_illegal} <= {alu_result, alu_zero, alu_illegal};
            if (gnt[1]) {rsp1_data, rsp1_zero, rsp1_illegal} <= {alu_result, alu_zero, alu_illegal};
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero, rsp0_illegal;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero, rsp1_illegal;
    logic [31:0] req0_a, req0_b, req1_a, req1_b, rsp0_data, rsp1_data;
    logic [3:0]  req0_op, req1_op;
    int          total = 0;
    int          bad = 0;

    localparam int N = 10;
    logic [3:0]  t_op [N] = '{OP_XOR, OP_XOR, OP_SLL, OP_SRA, OP_SLTU, OP_SUB, OP_ADD, OP_SRL, OP_OR, OP_AND};
    logic [31:0] t_a  [N] = '{32'hF0, 32'h1, 32'h1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, 32'h8000_0000, 32'hA0, 32'hF0F0};
    logic [31:0] t_b  [N] = '{32'hFF, 32'h1, 32'd40, 32'd4, 32'd1, 32'd5, 32'd1, 32'd31, 32'h0B, 32'hFF00};
    logic [31:0] t_r  [N] = '{32'h0F, 32'h0, 32'h0, 32'hF800_0000, 32'h0, 32'hFFFF_FFFE, 32'h0, 32'h1, 32'hAB, 32'hF000};

    always #5 clk = ~clk;

    alu_arbiter #(.DWIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_zero(rsp0_zero), .rsp0_illegal(rsp0_illegal),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_zero(rsp1_zero), .rsp1_illegal(rsp1_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_op = OP_ADD; rsp0_ready = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = OP_ADD; rsp1_ready = 1'b0;
        #7;
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp1_valid", rsp1_valid, 0);
        chk("rst_rsp0_data", rsp0_data, 0);
        chk("rst_req0_ready", req0_ready, 0);
        #3 rst_n = 1'b1;

        // single ADD on requester 0
        req0_a = 5; req0_b = 7; req0_op = OP_ADD; rsp0_ready = 1'b1;
        #1;
        chk("add_req0_ready", req0_ready, 1);
        chk("add_req1_ready", req1_ready, 0);
        cyc();
        chk("add_valid", rsp0_valid, 1);
        chk("add_data", rsp0_data, 12);
        chk("add_zero", rsp0_zero, 0);
        chk("add_illegal", rsp0_illegal, 0);
        req0_valid = 1'b0;
        cyc();
        chk("add_consumed", rsp0_valid, 0);

        // fresh reset, then both requesters contend
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        req0_valid = 1'b1; req0_a = 3; req0_b = 3; req0_op = OP_SUB;
        req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF; req1_b = 1; req1_op = OP_SLT;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_req0_ready", req0_ready, (i % 2) == 0);
            chk("rr_req1_ready", req1_ready, (i % 2) == 1);
            cyc();
            if (i % 2 == 0) begin
                chk("rr_rsp0_data", rsp0_data, 0);
                chk("rr_rsp0_zero", rsp0_zero, 1);
            end else begin
                chk("rr_rsp1_data", rsp1_data, 1);
                chk("rr_rsp1_zero", rsp1_zero, 0);
            end
        end

        // requester 0 stalls its response; requester 1 keeps flowing
        rsp0_ready = 1'b0; req0_a = 1; req0_b = 2; req0_op = OP_ADD;
        req1_a = 10; req1_b = 0; req1_op = OP_ADD;
        #1;
        chk("hol_first_req0", req0_ready, 1);
        cyc();
        chk("hol_first_data", rsp0_data, 3);
        for (int i = 0; i < 3; i++) begin
            req1_b = i;
            #1;
            chk("hol_req0_ready", req0_ready, 0);
            chk("hol_req1_ready", req1_ready, 1);
            cyc();
            chk("hol_rsp0_valid", rsp0_valid, 1);
            chk("hol_rsp0_held", rsp0_data, 3);
            chk("hol_rsp1_data", rsp1_data, 10 + i);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b1;
        cyc();
        chk("hol_drain", rsp0_valid, 0);

        // illegal opcode on requester 1
        req1_valid = 1'b1; req1_op = 4'b1100; req1_a = 9; req1_b = 9;
        #1;
        chk("ill_req1_ready", req1_ready, 1);
        cyc();
        chk("ill_data", rsp1_data, 0);
        chk("ill_zero", rsp1_zero, 1);
        chk("ill_flag", rsp1_illegal, 1);
        req1_valid = 1'b0;

        // back-to-back operations on requester 0, response consumed each cycle
        req0_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            req0_op = t_op[i]; req0_a = t_a[i]; req0_b = t_b[i];
            #1;
            chk("b2b_ready", req0_ready, 1);
            cyc();
            chk("b2b_valid", rsp0_valid, 1);
            chk("b2b_data", rsp0_data, t_r[i]);
            chk("b2b_zero", rsp0_zero, t_r[i] == 0);
            chk("b2b_illegal", rsp0_illegal, 0);
        end
        req0_valid = 1'b0;
        cyc();

        // fill slot 1, leave prio pointing at requester 1, then reset mid-cycle
        req1_valid = 1'b1; req1_op = OP_ADD; req1_a = 4; req1_b = 4; rsp1_ready = 1'b0;
        cyc();
        chk("rst_full_valid", rsp1_valid, 1);
        chk("rst_full_data", rsp1_data, 8);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 0; req0_b = 0;
        cyc();
        req0_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp1_valid", rsp1_valid, 0);
        chk("mid_rst_rsp1_data", rsp1_data, 0);
        chk("mid_rst_rsp0_valid", rsp0_valid, 0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("mid_rst_req0_ready", req0_ready, 0);
        chk("mid_rst_req1_ready", req1_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_req0_ready", req0_ready, 1);
        chk("post_rst_req1_ready", req1_ready, 0);
        cyc();
        chk("post_rst_rsp0_valid", rsp0_valid, 1);
        chk("post_rst_rsp1_valid", rsp1_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DWIDTH, default 32, operand/result width.
REQ-002 Clk  input  1  rising-edge clock; sole clock domain.
REQ-003 Rst_N  input  1  reset, asynchronous assert, active-low.
REQ-004 ReqN_Valid  input  1  requester N (N=0,1) operation valid.
REQ-005 ReqN_Ready  output  1  requester N operation accepted this cycle.
REQ-006 ReqN_A, ReqN_B  input  DWIDTH  operands A, B.
REQ-007 ReqN_Op  input  4  ALU opcode (ADD..AND encodings from shared defines).
REQ-008 RspN_Valid  output  1  requester N result valid.
REQ-009 RspN_Ready  input  1  requester N result consumed.
REQ-010 RspN_Data  output  DWIDTH  registered ALU result.
REQ-011 RspN_Zero  output  1  registered ALU zero flag.
REQ-012 RspN_Illegal  output  1  registered flag: opcode outside 0000-1001.

Function
REQ-013 Shall time-share one ALU instance between requesters 0 and 1; at most one operation enters the ALU per cycle.
REQ-014 Requester N is eligible when ReqN_Valid=1 and its response slot is free: RspN_Valid=0 or RspN_Ready=1 in the same cycle.
REQ-015 Grant: one eligible -> that one; both eligible -> requester selected by round-robin pointer Prio; none -> no grant.
REQ-016 ReqN_Ready=1 only for the granted requester; handshake = ReqN_Valid & ReqN_Ready.
REQ-017 Prio shall flip to the non-granted requester after every grant; unchanged in cycles with no grant.
REQ-018 Mux drives ALU inputs from the granted requester; ungranted cycles drive zero operands, opcode ADD.
REQ-019 Latency: handshake at edge k -> RspN_Valid=1 with Data/Zero/Illegal after edge k (one cycle).
REQ-020 RspN_Valid, RspN_Data, RspN_Zero, RspN_Illegal shall hold stable while RspN_Valid=1 and RspN_Ready=0.
REQ-021 RspN_Valid clears after an edge where RspN_Ready=1 and no new handshake for N; simultaneous consume + new handshake keeps RspN_Valid=1 with new data (back-to-back, one op/cycle/requester).
REQ-022 Illegal opcode (1010-1111): accepted normally; RspN_Data=0, RspN_Zero=1, RspN_Illegal=1.
REQ-023 Arithmetic per ALU semantics: wrap-around modulo 2^DWIDTH, shifts use full B value, SLT signed, SLTU unsigned.
REQ-024 Per-requester FSM: EMPTY (RspN_Valid=0) -> FULL on handshake; FULL -> EMPTY on RspN_Ready without handshake; FULL -> FULL on handshake (reload) or stall.
REQ-025 A requester with a full, unconsumed slot shall never be granted; the other requester shall be granted that cycle if valid (no head-of-line blocking).
REQ-026 Starvation bound: a continuously eligible requester shall be granted within 2 cycles.

Reset
REQ-027 Rst_N=0 shall immediately clear RspN_Valid, RspN_Data, RspN_Zero, RspN_Illegal to 0 and Prio to 0 (requester 0 favoured).
REQ-028 ReqN_Ready shall be 0 while Rst_N=0; in-flight results are discarded.
REQ-029 Deassertion of Rst_N shall be synchronised by the integrating top level; first grant possible on first edge after release.

Structure
REQ-030 ALU opcode encodings and the illegal-opcode bound (4'd9) shall come from the shared defines header.
REQ-031 Exactly one sub-module: the existing alu, instantiated once with DWIDTH passed through.
REQ-032 Arbiter, per-requester response registers and FSM state shall live in alu_arbiter; no other sub-modules.

Verification
REQ-033 Req0 ADD A=5 B=7 alone -> Req0_Ready=1 same cycle; next cycle Rsp0_Valid=1, Data=12, Zero=0, Illegal=0.
REQ-034 Both valid from reset, Req0 SUB 3-3, Req1 SLT A=0xFFFFFFFF B=1, Rsp ready=1 -> grant order 0,1,0,1; Rsp0 Data=0 Zero=1; Rsp1 Data=1.
REQ-035 Rsp0_Ready=0 with Rsp0 full, both requesting -> Req0_Ready=0, Req1 granted every cycle; Rsp0 Data held unchanged.
REQ-036 Req1 Op=4'b1100 A=9 B=9 -> Rsp1 Data=0, Zero=1, Illegal=1.
REQ-037 Back-to-back Req0 XOR (0xF0^0xFF, then 0x1^0x1) with Rsp0_Ready=1 -> Rsp0_Valid stays 1, Data 0x0F then 0x0, Zero 0 then 1.
REQ-038 Assert Rst_N=0 mid-cycle with Rsp1 full -> Rsp1_Valid=0 and Data=0 before next edge; after release, simultaneous requests grant Req0 first.
